// File: rtl/conv3x3_mac.sv
// 3x3 signed convolution MAC: slides a window over 3-row column stream, 2-stage product/sum pipeline.
// Optional build macro CONV_RELU_EN clamps negative sums to zero in the sum stage.
module conv3x3_mac #(
    parameter int SIZE = 14,
    parameter int DW   = 16,
    parameter int OW   = 36
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 w_load,
    input  logic signed [DW-1:0] w_in,
    output logic                 w_ready,
    input  logic                 in_valid,
    input  logic signed [DW-1:0] col1,
    input  logic signed [DW-1:0] col2,
    input  logic signed [DW-1:0] col3,
    output logic                 out_valid,
    output logic        [OW-1:0] out_data,
    output logic                 done
);

    localparam int unsigned CW  = (SIZE > 2) ? $clog2(SIZE) : 1;
    localparam int unsigned PW  = 2 * DW;
    localparam int unsigned IW  = 4;
    localparam int unsigned NTAP = 9;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD_W = 2'd1,
        READY  = 2'd2,
        RUN    = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic [IW-1:0]         widx_q, widx_d;
    logic signed [DW-1:0]  w_q [NTAP];
    logic signed [DW-1:0]  w_d [NTAP];
    // win_q[column][row]; column 0 is the oldest, row 0 is the top pixel
    logic signed [DW-1:0]  win_q [3][3];
    logic signed [DW-1:0]  win_d [3][3];
    logic [CW-1:0]         col_cnt_q, col_cnt_d;
    logic [CW-1:0]         band_cnt_q, band_cnt_d;
    logic                  win_vld_q, win_vld_d;
    logic                  win_last_q, win_last_d;
    logic signed [PW-1:0]  prod_q [NTAP];
    logic signed [PW-1:0]  prod_d [NTAP];
    logic                  p1_vld_q, p1_vld_d;
    logic                  p1_last_q, p1_last_d;
    logic                  out_valid_q, out_valid_d;
    logic [OW-1:0]         out_data_q, out_data_d;
    logic                  done_q, done_d;
    logic                  w_ready_q, w_ready_d;
    logic                  accept_c;
    logic signed [OW-1:0]  sum_c;

    // A column is taken only once weights are complete; a same-cycle reload in READY wins
    assign accept_c = in_valid && w_ready_q && !(state_q == READY && w_load);

    // Next-state, window shift, counters and pipeline stages
    always_comb begin
        state_d     = state_q;
        widx_d      = widx_q;
        w_d         = w_q;
        win_d       = win_q;
        col_cnt_d   = col_cnt_q;
        band_cnt_d  = band_cnt_q;
        win_vld_d   = 1'b0;
        win_last_d  = 1'b0;
        p1_vld_d    = win_vld_q;
        p1_last_d   = win_last_q;
        out_valid_d = p1_vld_q;
        done_d      = p1_vld_q && p1_last_q;
        out_data_d  = out_data_q;
        sum_c       = '0;
        for (int i = 0; i < int'(NTAP); i++) begin
            prod_d[i] = prod_q[i];
        end

        case (state_q)
            IDLE: begin
                if (w_load) begin
                    w_d[0]  = w_in;
                    widx_d  = IW'(1);
                    state_d = LOAD_W;
                end
            end
            LOAD_W: begin
                if (w_load) begin
                    w_d[widx_q] = w_in;
                    if (widx_q == IW'(NTAP - 1)) begin
                        widx_d  = '0;
                        state_d = READY;
                    end else begin
                        widx_d = widx_q + IW'(1);
                    end
                end
            end
            READY: begin
                // A strobe here restarts the load sequence with this word as w00
                if (w_load) begin
                    w_d[0]  = w_in;
                    widx_d  = IW'(1);
                    state_d = LOAD_W;
                end else if (in_valid) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (done_d) begin
                    state_d = READY;
                end
            end
            default: state_d = IDLE;
        endcase

        if (accept_c) begin
            win_d[0] = win_q[1];
            win_d[1] = win_q[2];
            win_d[2][0] = col1;
            win_d[2][1] = col2;
            win_d[2][2] = col3;
            win_vld_d   = (col_cnt_q >= CW'(2));
            win_last_d  = (col_cnt_q == CW'(SIZE - 1)) && (band_cnt_q == CW'(SIZE - 3));
            if (col_cnt_q == CW'(SIZE - 1)) begin
                col_cnt_d  = '0;
                band_cnt_d = (band_cnt_q == CW'(SIZE - 3)) ? '0 : band_cnt_q + CW'(1);
            end else begin
                col_cnt_d = col_cnt_q + CW'(1);
            end
        end

        if (win_vld_q) begin
            for (int r = 0; r < 3; r++) begin
                for (int c = 0; c < 3; c++) begin
                    prod_d[3*r+c] = PW'(w_q[3*r+c]) * PW'(win_q[c][r]);
                end
            end
        end

        for (int i = 0; i < int'(NTAP); i++) begin
            sum_c = sum_c + OW'(prod_q[i]);
        end
`ifdef CONV_RELU_EN
        if (sum_c[OW-1]) begin
            sum_c = '0;
        end
`endif
        if (p1_vld_q) begin
            out_data_d = OW'(sum_c);
        end

        w_ready_d = (state_d == READY) || (state_d == RUN);
    end

    // State and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            widx_q      <= '0;
            col_cnt_q   <= '0;
            band_cnt_q  <= '0;
            win_vld_q   <= 1'b0;
            win_last_q  <= 1'b0;
            p1_vld_q    <= 1'b0;
            p1_last_q   <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            done_q      <= 1'b0;
            w_ready_q   <= 1'b0;
            for (int i = 0; i < int'(NTAP); i++) begin
                w_q[i]    <= '0;
                prod_q[i] <= '0;
            end
            for (int c = 0; c < 3; c++) begin
                for (int r = 0; r < 3; r++) begin
                    win_q[c][r] <= '0;
                end
            end
        end else begin
            state_q     <= state_d;
            widx_q      <= widx_d;
            col_cnt_q   <= col_cnt_d;
            band_cnt_q  <= band_cnt_d;
            win_vld_q   <= win_vld_d;
            win_last_q  <= win_last_d;
            p1_vld_q    <= p1_vld_d;
            p1_last_q   <= p1_last_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            done_q      <= done_d;
            w_ready_q   <= w_ready_d;
            for (int i = 0; i < int'(NTAP); i++) begin
                w_q[i]    <= w_d[i];
                prod_q[i] <= prod_d[i];
            end
            for (int c = 0; c < 3; c++) begin
                for (int r = 0; r < 3; r++) begin
                    win_q[c][r] <= win_d[c][r];
                end
            end
        end
    end

    assign w_ready   = w_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign done      = done_q;

endmodule

// File: tb/tb_conv3x3_mac.sv
// Directed bench for conv3x3_mac: scoreboard of model-computed results with expected arrival cycle.
module tb_conv3x3_mac;

    localparam int SIZE = 14;
    localparam int DW   = 16;
    localparam int OW   = 36;
    localparam int NCOL = SIZE * (SIZE - 2);
    localparam int NRES = (SIZE - 2) * (SIZE - 2);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          w_load = 1'b0;
    logic [DW-1:0] w_in = '0;
    logic          w_ready;
    logic          in_valid = 1'b0;
    logic [DW-1:0] col1 = '0;
    logic [DW-1:0] col2 = '0;
    logic [DW-1:0] col3 = '0;
    logic          out_valid;
    logic [OW-1:0] out_data;
    logic          done;

    conv3x3_mac #(.SIZE(SIZE), .DW(DW), .OW(OW)) dut (
        .clk       (clk),
        .rst       (rst),
        .w_load    (w_load),
        .w_in      (w_in),
        .w_ready   (w_ready),
        .in_valid  (in_valid),
        .col1      (col1),
        .col2      (col2),
        .col3      (col3),
        .out_valid (out_valid),
        .out_data  (out_data),
        .done      (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [OW-1:0] data;
        logic          last;
        int            cyc;
    } exp_t;

    exp_t          q[$];
    logic [OW-1:0] got[$];
    int            tbw[9];
    int            n_cmp  = 0;
    int            n_err  = 0;
    int            n_done = 0;
    int            cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expd);
        n_cmp++;
        assert (obs === expd) else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expd);
        end
    endtask

    function automatic longint pix(input int mode, input int r, input int c);
        case (mode)
            0:       return longint'(SIZE * r + c);
            1:       return 64'sd1;
            default: return -64'sd32768;
        endcase
    endfunction

    function automatic logic [OW-1:0] expv(input int mode, input int b, input int c);
        longint s = 0;
        for (int r = 0; r < 3; r++)
            for (int k = 0; k < 3; k++)
                s += longint'(tbw[3*r+k]) * pix(mode, b + r, c - 2 + k);
`ifdef CONV_RELU_EN
        if (s < 0) s = 0;
`endif
        return OW'(s);
    endfunction

    // Scoreboard pop on every output beat
    always @(negedge clk) begin
        if (out_valid === 1'b1) begin
            got.push_back(out_data);
            if (q.size() == 0) begin
                chk("spurious_out_valid", 64'd1, 64'd0);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("out_data", 64'(out_data), 64'(e.data));
                chk("done_flag", 64'(done), 64'(e.last));
                chk("arrival_cycle", 64'(cyc), 64'(e.cyc));
            end
            if (done === 1'b1) n_done++;
        end else if (done === 1'b1) begin
            chk("done_without_valid", 64'd1, 64'd0);
        end
    end

    task automatic load_w(input int vals[9]);
        for (int i = 0; i < 9; i++) begin
            @(posedge clk); #1;
            w_load = 1'b1;
            w_in   = DW'(vals[i]);
            tbw[i] = vals[i];
        end
        @(posedge clk); #1;
        w_load = 1'b0;
    endtask

    task automatic stream(input int mode, input int gap, input int wl_at, input int ncols);
        for (int k = 0; k < ncols; k++) begin
            int b;
            int c;
            exp_t e;
            b = k / SIZE;
            c = k % SIZE;
            @(posedge clk); #1;
            in_valid = 1'b1;
            col1     = DW'(pix(mode, b, c));
            col2     = DW'(pix(mode, b + 1, c));
            col3     = DW'(pix(mode, b + 2, c));
            w_load   = (k == wl_at);
            w_in     = 16'h03E7;
            if (c >= 2) begin
                e.data = expv(mode, b, c);
                e.last = (b == SIZE - 3) && (c == SIZE - 1);
                e.cyc  = cyc + 3;
                q.push_back(e);
            end
            for (int g = 0; g < gap; g++) begin
                @(posedge clk); #1;
                in_valid = 1'b0;
                w_load   = 1'b0;
            end
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        w_load   = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 20; i++) begin
            if (q.size() == 0) break;
            @(negedge clk); #1;
        end
        chk("queue_drained", 64'(q.size()), 64'd0);
    endtask

    task automatic do_reset();
        @(negedge clk); #1;
        rst = 1'b1;
        q.delete();
        @(negedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic check_ramp_image(input string tag, input int d0);
        chk({tag, "_result_count"}, 64'(got.size()), 64'(NRES));
        chk({tag, "_done_count"}, 64'(n_done - d0), 64'd1);
        if (got.size() >= 13) begin
            chk({tag, "_first"}, 64'(got[0]), 64'd933);
            chk({tag, "_second"}, 64'(got[1]), 64'd978);
            chk({tag, "_band1_first"}, 64'(got[12]), 64'd1563);
        end
    endtask

    initial begin
        int ramp[9];
        int neg1[9];
        int most[9];
        int d0;
        for (int i = 0; i < 9; i++) begin
            ramp[i] = i + 1;
            neg1[i] = -1;
            most[i] = -32768;
        end

        // Reset values
        #3;
        chk("rst_w_ready", 64'(w_ready), 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_data", 64'(out_data), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        @(negedge clk); #1;
        rst = 1'b0;

        // Columns offered before the 9th weight must be dropped
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            w_load = 1'b1; w_in = DW'(ramp[i]); tbw[i] = ramp[i];
            in_valid = 1'b1; col1 = 16'h0100; col2 = 16'h0200; col3 = 16'h0300;
        end
        @(posedge clk); #1;
        w_load = 1'b0;
        @(posedge clk); #1;
        chk("w_ready_partial_load", 64'(w_ready), 64'd0);
        in_valid = 1'b0;
        w_load = 1'b1; w_in = DW'(ramp[8]); tbw[8] = ramp[8];
        @(posedge clk); #1;
        w_load = 1'b0;
        chk("w_ready_after_9th", 64'(w_ready), 64'd1);
        repeat (4) @(posedge clk);
        chk("no_output_before_stream", 64'(got.size()), 64'd0);

        // Ramp image, back-to-back, with an ignored reload strobe mid-run
        got.delete(); d0 = n_done;
        stream(0, 0, 20, NCOL);
        drain();
        check_ramp_image("ramp", d0);
        chk("w_ready_after_image", 64'(w_ready), 64'd1);

        // Same image with a bubble after every column
        got.delete(); d0 = n_done;
        stream(0, 1, -1, NCOL);
        drain();
        check_ramp_image("gapped", d0);

        // Negative sum: -9, or clamped to 0
        do_reset();
        load_w(neg1);
        got.delete(); d0 = n_done;
        stream(1, 0, -1, NCOL);
        drain();
        chk("neg_count", 64'(got.size()), 64'(NRES));
        if (got.size() > 0) begin
`ifdef CONV_RELU_EN
            chk("neg_first", 64'(got[0]), 64'd0);
`else
            chk("neg_first", 64'(got[0]), 64'h0000_000F_FFFF_FFF7);
`endif
        end

        // Largest magnitude products
        do_reset();
        load_w(most);
        got.delete(); d0 = n_done;
        stream(2, 0, -1, NCOL);
        drain();
        chk("max_count", 64'(got.size()), 64'(NRES));
        if (got.size() > 0) chk("max_first", 64'(got[0]), 64'd9663676416);

        // Mid-stream reset kills in-flight results and requires reload
        do_reset();
        load_w(ramp);
        got.delete();
        stream(0, 0, -1, 9);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk); #1;
            if (got.size() >= 5) break;
        end
        chk("results_before_rst", 64'(got.size()), 64'd5);
        rst = 1'b1;
        q.delete();
        #1;
        chk("rst_kills_valid", 64'(out_valid), 64'd0);
        chk("rst_kills_done", 64'(done), 64'd0);
        repeat (2) @(negedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            chk("post_rst_valid", 64'(out_valid), 64'd0);
        end
        chk("post_rst_w_ready", 64'(w_ready), 64'd0);
        load_w(ramp);
        got.delete(); d0 = n_done;
        stream(0, 0, -1, NCOL);
        drain();
        check_ramp_image("after_rst", d0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
